// File: rtl/float_acc_feeder.sv
// rtl/float_acc_feeder.sv - packs a float32 word stream into LANES-wide beats for the adder tree
//
// Purpose: collects serial float32 words into beats of LANES words, drives each
// completed beat onto the adder tree's parallel input (short final beats are padded
// with +0.0), and follows the tree's fixed latency with a valid/last/beat shift
// pipeline so the tree's free-running output is re-emitted as a framed stream.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_data/     serial input words, in_last marks the final word
//   in_last/in_ready      of a packet; in_ready = rst_n & !hold
//   hold                  downstream stall request, blocks input only
//   tree_din              packed beat to the tree, lane i = bits [32i+31:32i]
//   tree_dout             sum returned by the tree, TREE_LAT edges after tree_din
//   out_valid/out_data/   beat sum, end-of-packet flag and 0-based beat index;
//   out_last/out_beat     all zero while out_valid is low
`timescale 1ns/1ps
module float_acc_feeder #(
  parameter int LANES    = 4,
  parameter int TREE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 hold,
  output logic [LANES*32-1:0]  tree_din,
  input  logic [31:0]          tree_dout,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  output logic                 out_last,
  output logic [15:0]          out_beat
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  // Slot LANES-1 is never written: the word for the top lane always arrives as the
  // launching word and goes straight into tree_din, so that slot stays zero.
  logic [31:0]          fill_q [LANES];
  logic [31:0]          fill_d [LANES];
  logic [LANES*32-1:0]  tree_din_q, tree_din_d;
  logic [15:0]          bcnt_q, bcnt_d;
  logic [TREE_LAT:0]    sh_v_q, sh_v_d;
  logic [TREE_LAT:0]    sh_l_q, sh_l_d;
  logic [15:0]          sh_b_q [TREE_LAT+1];
  logic [15:0]          sh_b_d [TREE_LAT+1];

  logic accept;
  logic launch;

  assign in_ready = rst_n & ~hold;
  assign accept   = in_valid & in_ready;
  // A beat closes when its top lane fills or the packet ends early.
  assign launch   = accept & ((cnt_q == LAST_LANE) | in_last);

  always_comb begin
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    tree_din_d = tree_din_q;
    bcnt_d     = bcnt_q;

    if (launch) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < cnt_q) begin
          tree_din_d[32*i +: 32] = fill_q[i];
        end else if (CW'(i) == cnt_q) begin
          tree_din_d[32*i +: 32] = in_data;
        end else begin
          tree_din_d[32*i +: 32] = 32'h0000_0000;
        end
      end
      cnt_d = '0;
      for (int i = 0; i < LANES; i++) begin
        fill_d[i] = 32'h0000_0000;
      end
      bcnt_d = in_last ? 16'd0 : bcnt_q + 16'd1;
    end else if (accept) begin
      fill_d[cnt_q] = in_data;
      cnt_d         = cnt_q + 1'b1;
    end

    // Launch pipeline: non-launch edges push zeros, so the output stage carries
    // zero last/beat whenever valid is low.
    sh_v_d    = {sh_v_q[TREE_LAT-1:0], launch};
    sh_l_d    = {sh_l_q[TREE_LAT-1:0], launch & in_last};
    sh_b_d[0] = launch ? bcnt_q : 16'd0;
    for (int i = 1; i <= TREE_LAT; i++) begin
      sh_b_d[i] = sh_b_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tree_din_q <= '0;
      bcnt_q     <= 16'd0;
      sh_v_q     <= '0;
      sh_l_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        fill_q[i] <= 32'h0000_0000;
      end
      for (int i = 0; i <= TREE_LAT; i++) begin
        sh_b_q[i] <= 16'd0;
      end
    end else begin
      cnt_q      <= cnt_d;
      tree_din_q <= tree_din_d;
      bcnt_q     <= bcnt_d;
      sh_v_q     <= sh_v_d;
      sh_l_q     <= sh_l_d;
      fill_q     <= fill_d;
      sh_b_q     <= sh_b_d;
    end
  end

  assign tree_din  = tree_din_q;
  assign out_valid = sh_v_q[TREE_LAT];
  assign out_last  = sh_l_q[TREE_LAT];
  assign out_beat  = sh_b_q[TREE_LAT];
  assign out_data  = sh_v_q[TREE_LAT] ? tree_dout : 32'h0000_0000;

endmodule

// File: doc/float_acc_feeder.md
# float_acc_feeder

Upstream packing stage for the float32 adder-tree accumulator. It accepts a serial stream of IEEE-754 single-precision words with valid/ready/last framing and packs them into LANES-wide beats. It drives each beat onto the tree's parallel `din` bus, zero-padding short final beats. It tracks the fixed tree latency with a valid/last shift pipeline, so the tree's free-running `dout` is re-emitted as a framed, valid-qualified partial-sum stream.

## Interface

Parameters:
- LANES, 4: words per beat; power of two, ≥1; must equal the tree's add_num.
- TREE_LAT, 2: register stages in the tree instance, i.e. `tree_dout` reflects `tree_din` TREE_LAT edges after `tree_din` changes; ≥1; set by the integrator.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_data  in  32  float32 word.
- in_last  in  1  final word of packet; qualified by in_valid.
- in_ready  out  1  word accepted on an edge where in_valid & in_ready.
- hold  in  1  downstream stall request; forces in_ready low.
- tree_din  out  LANES*32  packed beat to the tree; lane i = bits [32i+31:32i].
- tree_dout  in  32  sum from the tree.
- out_valid  out  1  out_data carries a completed beat sum.
- out_data  out  32  beat sum; 0 when out_valid=0.
- out_last  out  1  beat was the final beat of its packet; 0 when out_valid=0.
- out_beat  out  16  beat index within packet (0-based); 0 when out_valid=0.

## Operation

- State:
  - lane counter `cnt` (0..LANES-1);
  - fill buffer of LANES-1 words;
  - `tree_din` register;
  - in-packet beat counter `bcnt` (16 bit);
  - launch pipeline `sh_v`, `sh_l`, `sh_b` of depth TREE_LAT+1.
- in_ready = rst_n & !hold, combinational. No other condition stalls input; the tree never back-pressures.
- Accept (in_valid & in_ready):
  - If neither `cnt==LANES-1` nor in_last: write in_data to fill lane `cnt` and increment `cnt`.
  - Otherwise this is a launch: on the same edge, load `tree_din` with fill lanes 0..cnt-1, in_data in lane `cnt`, and 0x00000000 (+0.0) in lanes cnt+1..LANES-1.
  - Also on a launch: set `cnt`=0, clear the fill buffer, push {1, in_last, bcnt} into stage 0 of the pipeline.
  - `bcnt` increments on each launch and resets to 0 on a launch with in_last.
- Non-launch edge: `tree_din` holds its value, and {0,0,0} is pushed into the pipeline.
- Pipeline shifts every edge. out_valid/out_last/out_beat = stage TREE_LAT; out_data = tree_dout when out_valid, else 0.
- LANES=1: every accepted word is a launch; the fill buffer is absent.
- `bcnt` wraps 0xFFFF→0 with no flag.
- A packet has no length limit. in_last on any lane closes the beat immediately.
- hold mid-beat preserves `cnt` and the fill buffer. In-flight launches continue to drain and emerge unaffected by hold.
- in_data values, including NaN/Inf/denormal, pass through unmodified. The block performs no arithmetic.

## Timing

- Reset: in_ready=0, `tree_din`=0, out_valid=0, out_data=0, out_last=0, out_beat=0, `cnt`=0, `bcnt`=0, pipeline cleared.
- Reset mid-operation:
  - the partial beat is discarded;
  - in-flight launches are dropped, so no out_valid occurs after release;
  - the first word after release goes to lane 0.
- Latency: launch on edge k → `tree_din` new after edge k → out_valid high in the cycle after edge k+TREE_LAT. Total latency is TREE_LAT+1 edges from the accepting edge.
- Throughput: one launch per cycle maximum (LANES=1 or single-word packets). Launches may be back-to-back, and out_valid may stay high continuously.
- A new packet's first word may be accepted on the edge immediately after the previous packet's last word.

## Test plan

- LANES=4, TREE_LAT=2, words 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with last on the 4th → `tree_din`={0x40800000, 0x40400000, 0x40000000, 0x3F800000} (lane3..0). One out_valid pulse with out_data=0x41200000, out_last=1, out_beat=0, 3 edges after acceptance.
- Short packet 0x3F800000 ×3 with last on the 3rd → lane3=0x00000000; out_data=0x40400000, out_last=1.
- 10-word packet, last on word 10 → 3 launches, out_beat 0, 1, 2; out_last only on beat 2; beat 2 has lanes 2 and 3 = 0.
- hold=1 for 5 cycles after 2 words → in_ready=0 and nothing accepted. The remaining 2 words complete the beat normally; the sum matches a no-hold run.
- Single-word packets every cycle → out_valid continuously high after 3 edges, each with out_last=1 and out_beat=0, and out_data tracking each word.
- rst_n low after 2 words of a beat, with a prior launch in flight → out_valid stays 0. After release, a fresh 4-word packet sums only the new words.
